con_bus_scheduler: RTL and testbench

Schedules the shared `con_1..con_3` I/O bus of `top_system` among three requesters: the weight loader (W), the activation loader (A) and the output drainer (O). It grants the bus to one requester at a time and caps each burst at `MAX_BURST` beats. It inserts a one-cycle turnaround whenever bus direction changes, and it drives `driving_cons` so the testbench and the DUT never drive the lanes together. It sits inside `top_system`, between the external handshake (`con_valid`/`con_ready`) and the loader/drainer datapath controllers.

---
 rtl/con_sched_pkg.sv | 20 ++
 rtl/con_arbiter.sv | 37 +++
 rtl/con_bus_scheduler.sv | 123 ++++++++++++
 tb/tb_con_bus_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/con_sched_pkg.sv
// Shared types and helpers for the con bus scheduler (state enum, requester
// indices, requester direction).
package con_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_GRANT = 2'd2
    } sched_state_t;

    localparam logic [1:0] REQ_W = 2'd0;
    localparam logic [1:0] REQ_A = 2'd1;
    localparam logic [1:0] REQ_O = 2'd2;

    // Only the output drainer drives the lanes outward.
    function automatic logic req_dir(input logic [1:0] idx);
        return (idx == REQ_O);
    endfunction

endpackage

// File: rtl/con_arbiter.sv
// Combinational winner selection for the con bus. With CON_SCHED_RR_EN the
// search is round-robin W->A->O starting after ptr; otherwise fixed O > W > A.
module con_arbiter
    import con_sched_pkg::*;
(
    input  logic [2:0] req,
`ifdef CON_SCHED_RR_EN
    input  logic [1:0] ptr,
`endif
    output logic [1:0] win,
    output logic       win_valid
);

`ifdef CON_SCHED_RR_EN
    logic [1:0] ord [3];

    always_comb begin
        case (ptr)
            REQ_W:   begin ord[0] = REQ_A; ord[1] = REQ_O; ord[2] = REQ_W; end
            REQ_A:   begin ord[0] = REQ_O; ord[1] = REQ_W; ord[2] = REQ_A; end
            default: begin ord[0] = REQ_W; ord[1] = REQ_A; ord[2] = REQ_O; end
        endcase
        win_valid = |req;
        if (req[ord[0]])      win = ord[0];
        else if (req[ord[1]]) win = ord[1];
        else                  win = ord[2];
    end
`else
    always_comb begin
        win_valid = |req;
        if (req[REQ_O])      win = REQ_O;
        else if (req[REQ_W]) win = REQ_W;
        else                 win = REQ_A;
    end
`endif

endmodule

// File: rtl/con_bus_scheduler.sv
// Grants the shared con bus to W, A or O with burst capping and a turnaround
// cycle on direction change. Optional round-robin arbitration: CON_SCHED_RR_EN.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate pending requests
// ST_TURN  | one dead cycle while the lane direction flips
// ST_GRANT | owner holds the bus; beats counted until last/cap/drop
module con_bus_scheduler
    import con_sched_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic [2:0]           req,
    input  logic [2:0]           last,
    input  logic                 con_valid,
    input  logic                 con_ready,
    output logic [2:0]           grant,
    output logic                 driving_cons,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic                 busy
);

    sched_state_t         state_q, state_d;
    logic                 dir_q, dir_d;
    logic [1:0]           owner_q, owner_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [2:0]           grant_d;
    logic                 drv_d;
    logic                 beat, cap_hit;
    logic [1:0]           win;
    logic                 win_valid;

`ifdef CON_SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;

    con_arbiter u_arbiter (
        .req       (req),
        .ptr       (ptr_q),
        .win       (win),
        .win_valid (win_valid)
    );
`else
    con_arbiter u_arbiter (
        .req       (req),
        .win       (win),
        .win_valid (win_valid)
    );
`endif

    assign beat    = con_valid & con_ready & (grant != 3'b000);
    assign cap_hit = (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        owner_d = owner_q;
        cnt_d   = beat_cnt;
`ifdef CON_SCHED_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (win_valid) begin
                    owner_d = win;
                    if (req_dir(win) == dir_q) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_TURN;
                        dir_d   = ~dir_q;
                    end
                end
            end
            ST_TURN: state_d = ST_GRANT;
            ST_GRANT: begin
                // A beat coinciding with the owner dropping req still completes.
                if ((beat && (last[owner_q] || cap_hit)) || !req[owner_q]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef CON_SCHED_RR_EN
                    ptr_d   = owner_q;
`endif
                end else if (beat) begin
                    cnt_d = beat_cnt + CNT_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        grant_d = 3'b000;
        if (state_d == ST_GRANT) grant_d[owner_d] = 1'b1;
        drv_d = (state_d == ST_GRANT) ? req_dir(owner_d) : ((state_d == ST_IDLE) & dir_d);
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            owner_q      <= REQ_W;
            beat_cnt     <= '0;
            grant        <= 3'b000;
            driving_cons <= 1'b0;
`ifdef CON_SCHED_RR_EN
            ptr_q        <= REQ_O;
`endif
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            owner_q      <= owner_d;
            beat_cnt     <= cnt_d;
            grant        <= grant_d;
            driving_cons <= drv_d;
`ifdef CON_SCHED_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_con_bus_scheduler.sv
// Self-checking bench for con_bus_scheduler: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_con_bus_scheduler;

    localparam int MB = 16;
    localparam int CW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst_in;
    logic [2:0]    req, last;
    logic          con_valid, con_ready;
    logic [2:0]    grant;
    logic          driving_cons;
    logic [CW-1:0] beat_cnt;
    logic          busy;

    con_bus_scheduler #(.MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .req          (req),
        .last         (last),
        .con_valid    (con_valid),
        .con_ready    (con_ready),
        .grant        (grant),
        .driving_cons (driving_cons),
        .beat_cnt     (beat_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: current owner (-1 none), pending winner across the turnaround,
    // lane direction, beats so far, last owner for round-robin
    int   m_owner, m_pend, m_cnt, m_ptr;
    bit   m_dir;
    int   rem [3];
    bit   rand_on = 1'b0;
    int   w;
    bit   bt;
    logic [2:0] eg;
    bit   ed, eb;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
`ifdef CON_SCHED_RR_EN
        for (int k = 1; k <= 3; k++) begin
            if (r[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
`else
        if (r[2]) return 2;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst_in) begin
            m_owner = -1; m_pend = -1; m_dir = 1'b0; m_cnt = 0; m_ptr = 2;
        end else if (m_owner >= 0) begin
            bt = con_valid && con_ready;
            if (bt) begin
                m_cnt++;
                if (rand_on && rem[m_owner] > 0) rem[m_owner]--;
            end
            if ((bt && (last[m_owner] || m_cnt == MB)) || !req[m_owner]) begin
                m_ptr = m_owner; m_owner = -1; m_cnt = 0;
            end
        end else if (m_pend >= 0) begin
            m_owner = m_pend; m_pend = -1;
        end else if (req != 3'b000) begin
            w = pick(req);
            if ((w == 2) == m_dir) m_owner = w;
            else begin m_pend = w; m_dir = !m_dir; end
        end
        #1;
        eg = 3'b000;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        ed = (m_owner >= 0) ? (m_owner == 2) : ((m_pend >= 0) ? 1'b0 : m_dir);
        eb = (m_owner >= 0) || (m_pend >= 0);
        chk("grant", grant, eg);
        chk("driving_cons", driving_cons, ed);
        chk("beat_cnt", beat_cnt, m_cnt);
        chk("busy", busy, eb);
    end

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_in = 1'b1; req = 3'b000; last = 3'b000; con_valid = 1'b0; con_ready = 1'b0;
        nx();
        rst_in = 1'b0;
    endtask

    int seg [$];
    int gaps [$];
    int own [$];
    int run, gap, done;
    bit started;
    logic [2:0] prev;

    initial begin
        rst_in = 1'b1; req = 3'b000; last = 3'b000; con_valid = 1'b0; con_ready = 1'b0;
        nx(); nx();
        rst_in = 1'b0;
        nx();
        chk("reset grant", grant, 0);
        chk("reset driving", driving_cons, 0);
        chk("reset beat_cnt", beat_cnt, 0);
        chk("reset busy", busy, 0);

        // W burst of 4 with last on beat 4
        req = 3'b001; con_valid = 1'b1; con_ready = 1'b1;
        nx();
        chk("w grant latency", grant, 3'b001);
        chk("w driving", driving_cons, 0);
        nx(); nx(); nx();
        chk("w beats before last", beat_cnt, 3);
        last = 3'b001;
        nx();
        chk("w grant after last", grant, 0);
        req = 3'b000; last = 3'b000;
        nx();

        // O from reset needs a turnaround
        do_reset();
        req = 3'b100;
        nx();
        chk("o turn grant", grant, 0);
        chk("o turn busy", busy, 1);
        nx();
        chk("o grant", grant, 3'b100);
        chk("o driving", driving_cons, 1);
        req = 3'b000;
        nx();
        chk("o exit grant", grant, 0);
        chk("o idle driving", driving_cons, 1);
        nx();

        // A 40-beat transfer split by the burst cap
        do_reset();
        req = 3'b010; con_valid = 1'b1; con_ready = 1'b1;
        run = 0; gap = 0; done = 0; started = 1'b0;
        for (int c = 0; c < 100 && !(done == 40 && grant == 3'b000); c++) begin
            nx();
            if (grant == 3'b010) begin
                if (gap > 0 && started) gaps.push_back(gap);
                gap = 0; started = 1'b1; run++;
                last = (done == 39) ? 3'b010 : 3'b000;
                done++;
            end else begin
                if (run > 0) seg.push_back(run);
                run = 0; gap++; last = 3'b000;
            end
        end
        req = 3'b000; last = 3'b000;
        chk("cap segments", seg.size(), 3);
        if (seg.size() == 3) begin
            chk("cap seg0", seg[0], 16);
            chk("cap seg1", seg[1], 16);
            chk("cap seg2", seg[2], 8);
        end
        chk("cap gaps", gaps.size(), 2);
        if (gaps.size() == 2) begin
            chk("cap gap0", gaps[0], 1);
            chk("cap gap1", gaps[1], 1);
        end
        nx();

        // all three requesting, single-beat transfers
        do_reset();
        req = 3'b111; last = 3'b111; con_valid = 1'b1; con_ready = 1'b1;
        prev = 3'b000;
        for (int c = 0; c < 40 && own.size() < 4; c++) begin
            nx();
            if (grant != 3'b000 && prev == 3'b000) own.push_back(int'(grant));
            prev = grant;
        end
        chk("arb count", own.size(), 4);
        if (own.size() == 4) begin
`ifdef CON_SCHED_RR_EN
            chk("arb 0", own[0], 1);
            chk("arb 1", own[1], 2);
            chk("arb 2", own[2], 4);
            chk("arb 3", own[3], 1);
`else
            chk("arb 0", own[0], 4);
            chk("arb 1", own[1], 4);
            chk("arb 2", own[2], 4);
            chk("arb 3", own[3], 4);
`endif
        end
        req = 3'b000; last = 3'b000;
        nx();

        // owner drops req in a beat cycle
        do_reset();
        req = 3'b001; con_valid = 1'b1; con_ready = 1'b1;
        nx(); nx();
        chk("drop cnt before", beat_cnt, 1);
        req = 3'b000;
        nx();
        chk("drop grant", grant, 0);
        chk("drop cnt", beat_cnt, 0);
        con_valid = 1'b0;
        nx();

        // reset mid O burst
        do_reset();
        req = 3'b100; con_valid = 1'b1; con_ready = 1'b1;
        nx(); nx();
        chk("rst o grant", grant, 3'b100);
        repeat (6) nx();
        chk("rst o cnt", beat_cnt, 6);
        rst_in = 1'b1;
        nx();
        chk("rst grant", grant, 0);
        chk("rst driving", driving_cons, 0);
        chk("rst cnt", beat_cnt, 0);
        rst_in = 1'b0; req = 3'b001;
        nx();
        chk("post rst w grant", grant, 3'b001);
        chk("post rst driving", driving_cons, 0);
        req = 3'b000; con_valid = 1'b0; con_ready = 1'b0;
        nx();

        // random traffic
        do_reset();
        for (int i = 0; i < 3; i++) rem[i] = 0;
        rand_on = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            nx();
            if ($urandom % 700 == 0) begin
                rst_in = 1'b1;
                for (int i = 0; i < 3; i++) rem[i] = 0;
            end else begin
                rst_in = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (rem[i] > 0 && $urandom % 64 == 0) rem[i] = 0;
                else if (rem[i] == 0 && $urandom % 6 == 0) rem[i] = $urandom_range(1, 40);
                req[i]  = (rem[i] > 0);
                last[i] = (rem[i] == 1);
            end
            con_valid = ($urandom % 4 != 0);
            con_ready = ($urandom % 4 != 0);
        end
        rand_on = 1'b0;
        rst_in = 1'b0; req = 3'b000; last = 3'b000; con_valid = 1'b0; con_ready = 1'b0;
        repeat (4) nx();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
